// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised, glitch-filtered bus sampling, frame decode with
// error flags, E0/F0 prefix folding and a first-word-fall-through output FIFO.
module ps2_rx_fifo #(
  parameter int unsigned SAMPLE_DIV    = 1000,
  parameter int unsigned FILTER_LEN    = 3,
  parameter int unsigned TIMEOUT_TICKS = 100,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ps2Clk,
  input  logic                        ps2Data,
  output logic [7:0]                  code,
  output logic                        ext,
  output logic                        brk,
  output logic                        valid,
  input  logic                        ready,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  input  logic                        clear_ovf,
  output logic                        parity_err,
  output logic                        frame_err
);

  localparam int unsigned DW = $clog2(SAMPLE_DIV);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_t;

  logic [DW-1:0] div_q;
  logic          tick;
  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_s, data_s;
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  logic          fall_q, bit_q;

  state_t        state_q;
  logic [10:0]   shreg_q;
  logic [3:0]    bitcnt_q;
  logic [TW-1:0] timer_q;
  logic          ext_pend_q, brk_pend_q;
  logic          push_q;
  logic [9:0]    push_data_q;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [9:0]    head_q;
  logic          full, pop, do_push;

  assign tick   = (div_q == DW'(SAMPLE_DIV - 1));
  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Bus idles high, so synchronisers and filter come out of reset at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
      fall_q      <= 1'b0;
      bit_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2Clk};
      data_sync_q <= {data_sync_q[0], ps2Data};
      fall_q      <= 1'b0;
      if (tick) begin
        if (clk_s == filt_q) begin
          fcnt_q <= '0;
        end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
          filt_q <= clk_s;
          fcnt_q <= '0;
          fall_q <= ~clk_s;
          bit_q  <= data_s;
        end else begin
          fcnt_q <= fcnt_q + 1'b1;
        end
      end
    end
  end

  // Frame bits shift in at the top, so after 11 edges the start bit sits at [0], stop at [10].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      timer_q     <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fall_q) begin
            shreg_q  <= {bit_q, shreg_q[10:1]};
            bitcnt_q <= 4'd1;
            timer_q  <= '0;
            state_q  <= StRecv;
          end
        end
        StRecv: begin
          if (fall_q) begin
            shreg_q  <= {bit_q, shreg_q[10:1]};
            bitcnt_q <= bitcnt_q + 4'd1;
            timer_q  <= '0;
            if (bitcnt_q == 4'd10) state_q <= StCheck;
          end else if (tick) begin
            if (timer_q == TW'(TIMEOUT_TICKS - 1)) begin
              frame_err  <= 1'b1;
              ext_pend_q <= 1'b0;
              brk_pend_q <= 1'b0;
              state_q    <= StIdle;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end
        StCheck: begin
          state_q <= StIdle;
          if (shreg_q[0] || !shreg_q[10]) begin
            frame_err  <= 1'b1;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
          end else if (!(^shreg_q[9:1])) begin
            parity_err <= 1'b1;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
          end else if (shreg_q[8:1] == 8'hE0) begin
            ext_pend_q <= 1'b1;
          end else if (shreg_q[8:1] == 8'hF0) begin
            brk_pend_q <= 1'b1;
          end else begin
            push_q      <= 1'b1;
            push_data_q <= {ext_pend_q, brk_pend_q, shreg_q[8:1]};
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign valid   = (count_q != '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = valid && ready;
  assign do_push = push_q && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !pop)      count_q <= count_q + 1'b1;
      else if (!do_push && pop) count_q <= count_q - 1'b1;
      if (clear_ovf)                   overflow <= 1'b0;
      else if (push_q && full && !pop) overflow <= 1'b1;
      // Remember the last presented head so outputs hold steady once the FIFO drains.
      if (valid) head_q <= mem[rd_ptr_q];
    end
  end

  assign {ext, brk, code} = valid ? mem[rd_ptr_q] : head_q;
  assign count = count_q;

endmodule
